// File: rtl/mem_io_responder_if.sv
// -----------------------------------------------------------------------------
// mem_io_responder_if
// Purpose: groups the CPU memory bus, the UART byte streams and the halt flag
//          that connect the memory/I-O responder to the rest of the system.
// Signals:
//   mem_a[31:0]     request address (CPU -> responder)
//   mem_wr          1 = write, 0 = read (CPU -> responder)
//   mem_wdata[7:0]  write byte (CPU -> responder)
//   mem_rdata[7:0]  read byte, one cycle after the read (responder -> CPU)
//   io_buffer_full  transmit FIFO near full (responder -> CPU)
//   rx_valid/rx_data/rx_ready  received UART byte stream into the responder
//   tx_valid/tx_data/tx_ready  UART transmit byte stream out of the responder
//   halt            sticky program-stop flag (responder -> system)
// Modports:
//   master : the CPU / UART / system side
//   slave  : the responder
// -----------------------------------------------------------------------------
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;

    modport master (
        output mem_a, mem_wr, mem_wdata, rx_valid, rx_data, tx_ready,
        input  mem_rdata, io_buffer_full, rx_ready, tx_valid, tx_data, halt
    );

    modport slave (
        input  mem_a, mem_wr, mem_wdata, rx_valid, rx_data, tx_ready,
        output mem_rdata, io_buffer_full, rx_ready, tx_valid, tx_data, halt
    );
endinterface

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Purpose: target side of the CPU byte-wide memory bus. Holds a byte RAM of
//          2^ADDR_WIDTH bytes and the I/O page at 0x3xxxx:
//            0x30000 read  : pop receive FIFO head (0x00 when empty)
//            0x30000 write : push byte to transmit FIFO (0x00 ignored)
//            0x30004-7 read: little-endian cycle-counter snapshot bytes
//            0x30004 write : push 0x00 to transmit FIFO and set halt
//          Read data is registered: a read in cycle N is visible in N+1 and
//          mem_rdata holds during write cycles.
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-high reset
//   bus     mem_io_responder_if.slave (memory bus, UART streams, halt)
// -----------------------------------------------------------------------------
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_BIT = 4,
    parameter int RX_DEPTH_BIT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    mem_io_responder_if.slave    bus
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_BIT;
    localparam int RX_DEPTH = 1 << RX_DEPTH_BIT;

    localparam logic [TX_DEPTH_BIT:0] TX_FULL_CNT = (TX_DEPTH_BIT+1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_BIT:0] TX_NEAR_CNT = (TX_DEPTH_BIT+1)'(TX_DEPTH - 2);
    localparam logic [RX_DEPTH_BIT:0] RX_FULL_CNT = (RX_DEPTH_BIT+1)'(RX_DEPTH);

    localparam logic [17:0] IO_UART  = 18'h30000;
    localparam logic [17:0] IO_CNT_0 = 18'h30004;
    localparam logic [17:0] IO_CNT_1 = 18'h30005;
    localparam logic [17:0] IO_CNT_2 = 18'h30006;
    localparam logic [17:0] IO_CNT_3 = 18'h30007;

    // Storage
    logic [7:0]              r_ram    [2**ADDR_WIDTH];
    logic [7:0]              r_tx_mem [TX_DEPTH];
    logic [7:0]              r_rx_mem [RX_DEPTH];

    logic [TX_DEPTH_BIT-1:0] r_tx_wptr;
    logic [TX_DEPTH_BIT-1:0] r_tx_rptr;
    logic [TX_DEPTH_BIT:0]   r_tx_count;
    logic [RX_DEPTH_BIT-1:0] r_rx_wptr;
    logic [RX_DEPTH_BIT-1:0] r_rx_rptr;
    logic [RX_DEPTH_BIT:0]   r_rx_count;

    logic [7:0]              r_rdata;
    logic [31:0]             r_counter;
    logic [31:0]             r_snap;
    logic                    r_halt;

    // Decode
    logic [17:0]             w_addr18;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic                    w_is_io;
    logic                    w_sel_uart;
    logic                    w_sel_cnt0;
    logic                    w_ram_we;
    logic                    w_unused_addr;

    // FIFO control
    logic                    w_tx_full;
    logic                    w_tx_empty;
    logic                    w_tx_push_req;
    logic [7:0]              w_tx_push_data;
    logic                    w_tx_push;
    logic                    w_tx_pop;
    logic                    w_rx_full;
    logic                    w_rx_empty;
    logic                    w_rx_push;
    logic                    w_rx_pop;

    // Read path
    logic [7:0]              w_io_rdata;
    logic [7:0]              w_rd_data;

    assign w_addr18      = bus.mem_a[17:0];
    assign w_ram_addr    = bus.mem_a[ADDR_WIDTH-1:0];
    assign w_is_io       = (w_addr18[17:16] == 2'b11);
    assign w_sel_uart    = (w_addr18 == IO_UART);
    assign w_sel_cnt0    = (w_addr18 == IO_CNT_0);
    assign w_ram_we      = bus.mem_wr && !w_is_io;
    assign w_unused_addr = &{1'b0, bus.mem_a[31:18]};

    assign w_tx_full      = (r_tx_count == TX_FULL_CNT);
    assign w_tx_empty     = (r_tx_count == {(TX_DEPTH_BIT+1){1'b0}});
    assign w_tx_push_req  = bus.mem_wr && ((w_sel_uart && (bus.mem_wdata != 8'h00)) || w_sel_cnt0);
    assign w_tx_push_data = w_sel_cnt0 ? 8'h00 : bus.mem_wdata;
    assign w_tx_pop       = !w_tx_empty && bus.tx_ready;
    // A simultaneous pop frees a slot, so a push to a full FIFO is still accepted.
    assign w_tx_push      = w_tx_push_req && (!w_tx_full || w_tx_pop);

    assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
    assign w_rx_empty = (r_rx_count == {(RX_DEPTH_BIT+1){1'b0}});
    assign w_rx_push  = bus.rx_valid && !w_rx_full;
    // Pop sees only stored entries; a byte arriving this cycle is not bypassed.
    assign w_rx_pop   = !bus.mem_wr && w_sel_uart && !w_rx_empty;

    // I/O and RAM read-data selection
    always_comb begin
        w_io_rdata = 8'h00;
        unique case (w_addr18)
            IO_UART:  w_io_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
            IO_CNT_0: w_io_rdata = r_counter[7:0];   // live value, snapshot loads now
            IO_CNT_1: w_io_rdata = r_snap[15:8];
            IO_CNT_2: w_io_rdata = r_snap[23:16];
            IO_CNT_3: w_io_rdata = r_snap[31:24];
            default:  w_io_rdata = 8'h00;
        endcase
        if (w_is_io) begin
            w_rd_data = w_io_rdata;
        end else begin
            w_rd_data = r_ram[w_ram_addr];
        end
    end

    // RAM write port (contents survive reset)
    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= bus.mem_wdata;
        end
    end

    // Registered read data; held during write cycles
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rdata <= 8'h00;
        end else if (!bus.mem_wr) begin
            r_rdata <= w_rd_data;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Cycle counter, halt flag and counter snapshot
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_counter <= 32'd0;
            r_snap    <= 32'd0;
            r_halt    <= 1'b0;
        end else begin
            if (!r_halt) begin
                r_counter <= r_counter + 32'd1;
            end
            if (!bus.mem_wr && w_sel_cnt0) begin
                r_snap <= r_counter;
            end
            if (bus.mem_wr && w_sel_cnt0) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Transmit FIFO storage
    always_ff @(posedge clk_in) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= w_tx_push_data;
        end
    end

    // Transmit FIFO pointers and occupancy
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_wptr  <= {TX_DEPTH_BIT{1'b0}};
            r_tx_rptr  <= {TX_DEPTH_BIT{1'b0}};
            r_tx_count <= {(TX_DEPTH_BIT+1){1'b0}};
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + TX_DEPTH_BIT'(1);
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + TX_DEPTH_BIT'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + (TX_DEPTH_BIT+1)'(1);
                2'b01:   r_tx_count <= r_tx_count - (TX_DEPTH_BIT+1)'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // Receive FIFO storage
    always_ff @(posedge clk_in) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= bus.rx_data;
        end
    end

    // Receive FIFO pointers and occupancy
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_wptr  <= {RX_DEPTH_BIT{1'b0}};
            r_rx_rptr  <= {RX_DEPTH_BIT{1'b0}};
            r_rx_count <= {(RX_DEPTH_BIT+1){1'b0}};
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + RX_DEPTH_BIT'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + RX_DEPTH_BIT'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + (RX_DEPTH_BIT+1)'(1);
                2'b01:   r_rx_count <= r_rx_count - (RX_DEPTH_BIT+1)'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Stream and status outputs depend only on state registers
    assign bus.mem_rdata      = r_rdata;
    assign bus.halt           = r_halt;
    assign bus.tx_valid       = !w_tx_empty;
    assign bus.tx_data        = r_tx_mem[r_tx_rptr];
    assign bus.rx_ready       = !w_rx_full;
    assign bus.io_buffer_full = (r_tx_count >= TX_NEAR_CNT);

endmodule

// File: tb/tb_mem_io_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_io_responder
// Directed bench for mem_io_responder: RAM access, transmit/receive FIFOs,
// back-pressure, counter snapshot, halt and reset. Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mem_io_responder;

    logic clk_in = 1'b0;
    logic rst_in;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .ADDR_WIDTH   (17),
        .TX_DEPTH_BIT (4),
        .RX_DEPTH_BIT (4)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_tx [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Idle request: write to an unmapped I/O address (no effect, rdata held)
    task automatic idle;
        bus.mem_a     = 32'h0003_0010;
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = 8'h00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a     = a;
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        bus.mem_a     = a;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = 8'h00;
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_in       = 1'b1;
        idle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_rdata", 32'(bus.mem_rdata), 32'h00);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_ibf", 32'(bus.io_buffer_full), 32'd0);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        rst_in = 1'b0;

        // RAM
        wr(32'h0000_1234, 8'hA5);
        rd(32'h0000_1234);
        chk("ram_1234", 32'(bus.mem_rdata), 32'hA5);
        wr(32'h0001_FFFF, 8'h3C);
        rd(32'h0001_FFFF);
        chk("ram_1ffff", 32'(bus.mem_rdata), 32'h3C);
        tick();
        chk("rdata_hold", 32'(bus.mem_rdata), 32'h3C);
        rd(32'h0000_1234);
        chk("ram_1234_again", 32'(bus.mem_rdata), 32'hA5);

        // Transmit FIFO fill with back-pressure
        wr(32'h0003_0000, 8'h48);
        wr(32'h0003_0000, 8'h69);
        wr(32'h0003_0000, 8'h00);
        chk("tx_valid_2", 32'(bus.tx_valid), 32'd1);
        chk("tx_head_H", 32'(bus.tx_data), 32'h48);
        chk("ibf_cnt2", 32'(bus.io_buffer_full), 32'd0);
        for (int k = 0; k < 11; k++) begin
            wr(32'h0003_0000, 8'(8'h10 + k));
        end
        chk("ibf_cnt13", 32'(bus.io_buffer_full), 32'd0);
        wr(32'h0003_0000, 8'h1B);
        chk("ibf_cnt14", 32'(bus.io_buffer_full), 32'd1);
        wr(32'h0003_0000, 8'h1C);
        wr(32'h0003_0000, 8'h1D);
        wr(32'h0003_0000, 8'hEE);          // full: dropped
        bus.tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h55);          // full with pop: accepted
        bus.tx_ready = 1'b0;
        chk("ibf_full_pushpop", 32'(bus.io_buffer_full), 32'd1);

        exp_tx[0] = 8'h69;
        for (int k = 0; k < 14; k++) begin
            exp_tx[k+1] = 8'(8'h10 + k);
        end
        exp_tx[15] = 8'h55;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_drain_%0d", i), 32'(bus.tx_data), 32'(exp_tx[i]));
            tick();
        end
        chk("tx_empty_after_drain", 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;

        // Receive FIFO
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        rd(32'h0003_0000);                 // empty pop with push: no bypass
        chk("rx_empty_pop", 32'(bus.mem_rdata), 32'h00);
        bus.rx_data = 8'h42;
        tick();
        bus.rx_valid = 1'b0;
        rd(32'h0003_0000);
        chk("rx_pop_41", 32'(bus.mem_rdata), 32'h41);
        rd(32'h0003_0000);
        chk("rx_pop_42", 32'(bus.mem_rdata), 32'h42);
        rd(32'h0003_0000);
        chk("rx_pop_empty", 32'(bus.mem_rdata), 32'h00);
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            bus.rx_data = 8'(8'h80 + k);
            tick();
        end
        chk("rx_ready_15", 32'(bus.rx_ready), 32'd1);
        bus.rx_data = 8'h8F;
        tick();
        chk("rx_ready_16", 32'(bus.rx_ready), 32'd0);
        bus.rx_data = 8'hEE;
        tick();                            // full: not accepted
        bus.rx_valid = 1'b0;
        rd(32'h0003_0000);
        chk("rx_pop_80", 32'(bus.mem_rdata), 32'h80);
        chk("rx_ready_after_pop", 32'(bus.rx_ready), 32'd1);
        rd(32'h0003_0000);
        chk("rx_pop_81", 32'(bus.mem_rdata), 32'h81);

        // Cycle counter snapshot
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        repeat (100) tick();
        rd(32'h0003_0004);
        chk("cnt_b0", 32'(bus.mem_rdata), 32'h64);
        rd(32'h0003_0005);
        chk("cnt_b1", 32'(bus.mem_rdata), 32'h00);
        rd(32'h0003_0006);
        chk("cnt_b2", 32'(bus.mem_rdata), 32'h00);
        rd(32'h0003_0007);
        chk("cnt_b3", 32'(bus.mem_rdata), 32'h00);
        rd(32'h0003_0004);
        chk("cnt_b0_live", 32'(bus.mem_rdata), 32'h68);

        // Halt
        chk("halt_before", 32'(bus.halt), 32'd0);
        wr(32'h0003_0004, 8'h00);
        chk("halt_set", 32'(bus.halt), 32'd1);
        chk("halt_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("halt_tx_zero", 32'(bus.tx_data), 32'h00);
        repeat (5) tick();
        rd(32'h0003_0004);
        chk("cnt_frozen", 32'(bus.mem_rdata), 32'h6A);
        bus.tx_ready = 1'b1;
        tick();
        chk("tx_drain_after_halt", 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;
        wr(32'h0003_0000, 8'h33);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h44;
        tick();
        bus.rx_valid = 1'b0;
        chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'd1);

        // Reset mid-operation
        rst_in = 1'b1;
        tick();
        chk("rst2_halt", 32'(bus.halt), 32'd0);
        chk("rst2_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst2_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst2_rdata", 32'(bus.mem_rdata), 32'h00);
        chk("rst2_ibf", 32'(bus.io_buffer_full), 32'd0);
        rst_in = 1'b0;
        rd(32'h0003_0000);
        chk("rst2_rx_empty", 32'(bus.mem_rdata), 32'h00);
        rd(32'h0003_0004);
        chk("rst2_cnt", 32'(bus.mem_rdata), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
